// File: rtl/wimpfi_txd_pkg.sv
// ============================================================
// wimpfi_txd_pkg -- shared types and defaults for the TXD write path
// Revision: 1.0
// ============================================================
`default_nettype none

package wimpfi_txd_pkg;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_NUM_BUF = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITING = 2'd1,
      CLOSE   = 2'd2,
      STALL   = 2'd3
   } txd_state_t;

endpackage

`default_nettype wire

// File: rtl/txd_buf_ring.sv
// ============================================================
// txd_buf_ring -- write/transmit ring pointers, occupancy and frame length file
// Revision: 1.0
// ============================================================
`default_nettype none

module txd_buf_ring
   import wimpfi_txd_pkg::*;
#(
   parameter  int ADDR_W  = DEF_ADDR_W,
   parameter  int NUM_BUF = DEF_NUM_BUF,
   localparam int BUF_W   = $clog2(NUM_BUF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              store,
   input  logic [ADDR_W:0]   store_len,
   input  logic              close,
   input  logic              tx_done,
   output logic [BUF_W-1:0]  wb,
   output logic [BUF_W-1:0]  tb,
   output logic              tx_req,
   output logic              full,
   output logic              has_free_next,
   output logic [ADDR_W:0]   tx_len
);

   localparam logic [BUF_W:0] OCC_MAX = (BUF_W+1)'(NUM_BUF);

   logic [BUF_W:0]  occupied;
   logic [BUF_W:0]  occ_next;
   logic            release_buf;
   logic [ADDR_W:0] len_q [NUM_BUF];

   // a release with nothing pending is meaningless and must not underflow
   always_comb begin
      release_buf   = tx_done && (occupied != '0);
      occ_next      = occupied + (BUF_W+1)'(close) - (BUF_W+1)'(release_buf);
      has_free_next = (occ_next != OCC_MAX);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb       <= '0;
         tb       <= '0;
         occupied <= '0;
      end else begin
         wb       <= wb + BUF_W'(close);
         tb       <= tb + BUF_W'(release_buf);
         occupied <= occ_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_BUF; i++) begin
            len_q[i] <= '0;
         end
      end else if (store) begin
         len_q[wb] <= store_len;
      end
   end

   assign tx_req = (occupied != '0);
   assign full   = (occupied == OCC_MAX);
   assign tx_len = len_q[tb];

endmodule

`default_nettype wire

// File: rtl/txd_write_ctrl.sv
// ============================================================
// txd_write_ctrl -- frame write controller feeding a ring of transmit buffers
// Revision: 1.0
// ============================================================
`default_nettype none

module txd_write_ctrl
   import wimpfi_txd_pkg::*;
#(
   parameter  int ADDR_W  = DEF_ADDR_W,
   parameter  int NUM_BUF = DEF_NUM_BUF,
   localparam int BUF_W   = $clog2(NUM_BUF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              XWR,
   input  logic              XSEND,
   output logic              wen,
   output logic [ADDR_W-1:0] w_addr,
   output logic [BUF_W-1:0]  w_buf,
   output logic              done_writing,
   output logic              tx_req,
   output logic [BUF_W-1:0]  tx_buf,
   output logic [ADDR_W:0]   tx_len,
   input  logic              tx_done,
   output logic              full,
   output logic              ovf
);

   txd_state_t        state;
   txd_state_t        next_state;
   logic [ADDR_W-1:0] ptr;
   logic [BUF_W-1:0]  wb;
   logic              accept;
   logic              last_byte;
   logic              close_req;
   logic              close;
   logic              drop;
   logic              has_free_next;
   logic [ADDR_W:0]   store_len;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // XSEND only counts once at least one byte exists; a last-address byte
   // closes on its own, so a coincident XSEND folds into the same close
   always_comb begin
      next_state = state;
      accept     = XWR && ((state == IDLE) || (state == WRITING));
      last_byte  = accept && (ptr == '1);
      close_req  = last_byte || (XSEND && (state == WRITING));
      close      = (state == CLOSE);
      drop       = (state == STALL) && (XWR || XSEND);
      store_len  = {1'b0, ptr} + (ADDR_W+1)'(accept);

      case (state)
         IDLE: begin
            if (close_req) begin
               next_state = CLOSE;
            end else if (accept) begin
               next_state = WRITING;
            end
         end
         WRITING: begin
            if (close_req) begin
               next_state = CLOSE;
            end
         end
         CLOSE: begin
            next_state = has_free_next ? IDLE : STALL;
         end
         STALL: begin
            if (tx_done) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr          <= '0;
         wen          <= 1'b0;
         w_addr       <= '0;
         w_buf        <= '0;
         done_writing <= 1'b0;
         ovf          <= 1'b0;
      end else begin
         if (close) begin
            ptr <= '0;
         end else if (accept) begin
            ptr <= ptr + ADDR_W'(1);
         end
         wen <= accept;
         if (accept) begin
            w_addr <= ptr;
            w_buf  <= wb;
         end
         done_writing <= close_req;
         ovf          <= ovf | drop;
      end
   end

   txd_buf_ring #(
      .ADDR_W  (ADDR_W),
      .NUM_BUF (NUM_BUF)
   ) u_ring (
      .clk           (clk),
      .reset         (reset),
      .store         (close_req),
      .store_len     (store_len),
      .close         (close),
      .tx_done       (tx_done),
      .wb            (wb),
      .tb            (tx_buf),
      .tx_req        (tx_req),
      .full          (full),
      .has_free_next (has_free_next),
      .tx_len        (tx_len)
   );

endmodule

`default_nettype wire

// File: tb/tb_txd_write_ctrl.sv
// ============================================================
// tb_txd_write_ctrl -- vector table, directed corner cases and a queue-based reference model
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_txd_write_ctrl;

   localparam int AW    = 8;
   localparam int NB    = 2;
   localparam int BW    = 1;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          reset;
   logic          XWR;
   logic          XSEND;
   logic          tx_done;
   logic          wen;
   logic [AW-1:0] w_addr;
   logic [BW-1:0] w_buf;
   logic          done_writing;
   logic          tx_req;
   logic [BW-1:0] tx_buf;
   logic [AW:0]   tx_len;
   logic          full;
   logic          ovf;

   int n_tests = 0;
   int n_fail  = 0;

   txd_write_ctrl #(.ADDR_W(AW), .NUM_BUF(NB)) dut (
      .clk          (clk),
      .reset        (reset),
      .XWR          (XWR),
      .XSEND        (XSEND),
      .wen          (wen),
      .w_addr       (w_addr),
      .w_buf        (w_buf),
      .done_writing (done_writing),
      .tx_req       (tx_req),
      .tx_buf       (tx_buf),
      .tx_len       (tx_len),
      .tx_done      (tx_done),
      .full         (full),
      .ovf          (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   // reference model: pending frames as a FIFO of {buffer, length}
   int m_len, m_close_len, m_wb;
   bit m_closing, m_stalled, m_ovf;
   int q_buf[$];
   int q_len[$];
   bit e_wen, e_done, e_req, e_full;
   int e_addr, e_buf, e_txbuf, e_txlen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_len = 0; m_close_len = 0; m_wb = 0;
      m_closing = 0; m_stalled = 0; m_ovf = 0;
      q_buf.delete(); q_len.delete();
   endtask

   task automatic model_pop();
      void'(q_buf.pop_front());
      void'(q_len.pop_front());
   endtask

   task automatic model_step(input bit xw, input bit xs, input bit td);
      int was;
      e_wen  = 0;
      e_done = 0;
      if (m_closing) begin
         if (td && q_len.size() > 0) model_pop();
         q_buf.push_back(m_wb);
         q_len.push_back(m_close_len);
         m_wb      = (m_wb + 1) % NB;
         m_len     = 0;
         m_closing = 0;
         m_stalled = (q_len.size() == NB);
      end else if (m_stalled) begin
         if (xw || xs) m_ovf = 1;
         if (td) begin
            model_pop();
            m_stalled = 0;
         end
      end else begin
         if (td && q_len.size() > 0) model_pop();
         was = m_len;
         if (xw) begin
            e_wen  = 1;
            e_addr = m_len;
            e_buf  = m_wb;
            m_len++;
         end
         if ((xs && was > 0) || (xw && m_len == DEPTH)) begin
            m_closing   = 1;
            m_close_len = m_len;
            e_done      = 1;
         end
      end
      e_req  = (q_len.size() > 0);
      e_full = (q_len.size() == NB);
      if (e_req) begin
         e_txbuf = q_buf[0];
         e_txlen = q_len[0];
      end
   endtask

   task automatic model_check();
      chk("model.wen", wen, e_wen);
      if (e_wen) begin
         chk("model.w_addr", w_addr, e_addr);
         chk("model.w_buf", w_buf, e_buf);
      end
      chk("model.done_writing", done_writing, e_done);
      chk("model.tx_req", tx_req, e_req);
      if (e_req) begin
         chk("model.tx_buf", tx_buf, e_txbuf);
         chk("model.tx_len", tx_len, e_txlen);
      end
      chk("model.full", full, e_full);
      chk("model.ovf", ovf, m_ovf);
   endtask

   task automatic step(input bit xw, input bit xs, input bit td);
      XWR = xw; XSEND = xs; tx_done = td;
      @(posedge clk);
      model_step(xw, xs, td);
      #1;
      model_check();
   endtask

   task automatic do_reset();
      XWR = 0; XSEND = 0; tx_done = 0;
      reset = 1'b0;
      #2;
      chk("rst.wen", wen, 0);
      chk("rst.w_addr", w_addr, 0);
      chk("rst.w_buf", w_buf, 0);
      chk("rst.done_writing", done_writing, 0);
      chk("rst.tx_req", tx_req, 0);
      chk("rst.tx_buf", tx_buf, 0);
      chk("rst.tx_len", tx_len, 0);
      chk("rst.full", full, 0);
      chk("rst.ovf", ovf, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   typedef struct {
      bit xwr; bit xsend; bit txd;
      bit wen; int addr; int bufi;
      bit done; bit req; int txbuf; int txlen;
      bit full; bit ovf;
   } vec_t;

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{1,0,0, 1,0,0, 0,0,0,0, 0,0};
      tbl[1]  = '{1,0,0, 1,1,0, 0,0,0,0, 0,0};
      tbl[2]  = '{1,1,0, 1,2,0, 1,0,0,0, 0,0};
      tbl[3]  = '{0,0,0, 0,0,0, 0,1,0,3, 0,0};
      tbl[4]  = '{0,1,0, 0,0,0, 0,1,0,3, 0,0};
      tbl[5]  = '{1,0,0, 1,0,1, 0,1,0,3, 0,0};
      tbl[6]  = '{0,1,0, 0,0,0, 1,1,0,3, 0,0};
      tbl[7]  = '{0,0,0, 0,0,0, 0,1,0,3, 1,0};
      tbl[8]  = '{1,0,0, 0,0,0, 0,1,0,3, 1,1};
      tbl[9]  = '{0,0,1, 0,0,0, 0,1,1,1, 0,1};
      tbl[10] = '{1,0,0, 1,0,0, 0,1,1,1, 0,1};
      tbl[11] = '{0,1,1, 0,0,0, 1,0,0,0, 0,1};
      tbl[12] = '{0,0,0, 0,0,0, 0,1,0,1, 0,1};

      XWR = 0; XSEND = 0; tx_done = 0;
      reset = 1'b1;
      #1;

      // vector table
      do_reset();
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].xwr, tbl[i].xsend, tbl[i].txd);
         chk($sformatf("vec%0d.wen", i), wen, tbl[i].wen);
         if (tbl[i].wen) begin
            chk($sformatf("vec%0d.w_addr", i), w_addr, tbl[i].addr);
            chk($sformatf("vec%0d.w_buf", i), w_buf, tbl[i].bufi);
         end
         chk($sformatf("vec%0d.done", i), done_writing, tbl[i].done);
         chk($sformatf("vec%0d.tx_req", i), tx_req, tbl[i].req);
         if (tbl[i].req) begin
            chk($sformatf("vec%0d.tx_buf", i), tx_buf, tbl[i].txbuf);
            chk($sformatf("vec%0d.tx_len", i), tx_len, tbl[i].txlen);
         end
         chk($sformatf("vec%0d.full", i), full, tbl[i].full);
         chk($sformatf("vec%0d.ovf", i), ovf, tbl[i].ovf);
      end

      // basic 20-byte frame
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0);
         chk("basic.wen", wen, 1);
         chk("basic.w_addr", w_addr, i);
         chk("basic.w_buf", w_buf, 0);
      end
      step(0, 1, 0);
      chk("basic.done", done_writing, 1);
      chk("basic.wen_off", wen, 0);
      step(0, 0, 0);
      chk("basic.done_once", done_writing, 0);
      chk("basic.tx_req", tx_req, 1);
      chk("basic.tx_len", tx_len, 20);
      chk("basic.tx_buf", tx_buf, 0);

      // XWR and XSEND together on the sixth byte
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      step(1, 1, 0);
      chk("same.wen", wen, 1);
      chk("same.w_addr", w_addr, 5);
      chk("same.done", done_writing, 1);
      step(0, 0, 0);
      chk("same.tx_len", tx_len, 6);
      step(1, 0, 0);
      chk("same.next_buf", w_buf, 1);
      chk("same.next_addr", w_addr, 0);

      // auto-close at the last address
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 0, 0);
         chk("auto.w_addr", w_addr, i);
         chk("auto.done", done_writing, (i == DEPTH - 1));
      end
      step(0, 1, 0);
      chk("auto.no_double", done_writing, 0);
      chk("auto.tx_len", tx_len, DEPTH);
      step(0, 1, 0);
      chk("auto.idle_send", done_writing, 0);
      chk("auto.ovf", ovf, 0);

      // stall with every buffer occupied
      do_reset();
      for (int f = 0; f < NB; f++) begin
         step(1, 0, 0);
         step(0, 1, 0);
         step(0, 0, 0);
      end
      chk("stall.full", full, 1);
      step(1, 0, 0);
      chk("stall.wen", wen, 0);
      chk("stall.ovf", ovf, 1);
      step(0, 0, 1);
      chk("stall.full_clr", full, 0);
      step(1, 0, 0);
      chk("stall.wen_resume", wen, 1);
      chk("stall.buf0", w_buf, 0);
      chk("stall.addr0", w_addr, 0);

      // reset in the middle of a frame
      do_reset();
      for (int i = 0; i < 7; i++) step(1, 0, 0);
      do_reset();
      chk("midrst.tx_req", tx_req, 0);
      step(1, 0, 0);
      chk("midrst.wen", wen, 1);
      chk("midrst.w_buf", w_buf, 0);
      chk("midrst.w_addr", w_addr, 0);

      // random traffic, frequent sends
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10);
      end

      // random traffic, long frames reaching auto-close and stalls
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         step($urandom_range(0, 99) < 90, $urandom_range(0, 999) < 2, $urandom_range(0, 99) < 3);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
